// File: rtl/lzc_reg.sv
// lzc_reg: leading-zero counter with one register stage and a valid qualifier.
// The count is the number of zero bits from bit W-1 down to the first set bit.
// If data_i is all zero, the count is W.
// The count is built as a log-depth binary tree over the input. The input is padded
// on the LSB side with ones up to the next power of two.
// Optional build macro LZC_ZERO_FLAG_EN adds a registered zero_o flag (data_i == 0).
module lzc_reg #(
   parameter int unsigned W     = 16,
   // Derived; wide enough to hold the value W. Do not override.
   parameter int unsigned CNT_W = $clog2(W + 1)
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             valid_i,
   input  logic [W-1:0]     data_i,
`ifdef LZC_ZERO_FLAG_EN
   output logic             zero_o,
`endif
   output logic             valid_o,
   output logic [CNT_W-1:0] cnt_o
);

   // Tree depth and padded width. W >= 2, so there is at least one merge level.
   localparam int unsigned L = $clog2(W);
   localparam int unsigned P = 1 << L;

   typedef logic [L-1:0] node_cnt_t;

   logic [P-1:0]     padded;
   logic             node_vld [0:L][0:P-1];
   node_cnt_t        node_cnt [0:L][0:P-1];
   logic             root_vld;
   node_cnt_t        root_cnt;
   logic [CNT_W-1:0] lzc_d;
   logic [CNT_W-1:0] cnt_q;
   logic             valid_q;

   // Place data_i at the MSB end and fill the remaining LSBs with ones.
   // When W < P, an all-zero input finds its first one at position W. This makes the
   // count exactly W with no special case.
   always_comb begin
      padded            = '1;
      padded[P-1 -: W]  = data_i;
   end

   // Reduction tree. Node n at level lv covers padded[n*2^lv +: 2^lv].
   // node_vld means the node contains a one. node_cnt is the number of leading zeros
   // inside the node. node_cnt is only meaningful when node_vld is set.
   always_comb begin
      for (int lv = 0; lv <= int'(L); lv++) begin
         for (int n = 0; n < int'(P); n++) begin
            node_vld[lv][n] = 1'b0;
            node_cnt[lv][n] = '0;
         end
      end
      for (int n = 0; n < int'(P); n++) begin
         node_vld[0][n] = padded[n];
      end
      for (int lv = 1; lv <= int'(L); lv++) begin
         for (int n = 0; n < int'(P / 2); n++) begin
            if (n < int'(P >> lv)) begin
               node_vld[lv][n] = node_vld[lv-1][2*n+1] | node_vld[lv-1][2*n];
               // Upper half wins if it holds a one.
               // Otherwise add the full width of the upper half, 2^(lv-1), to the lower
               // half's count. The lower count is < 2^(lv-1), so OR is the same as add.
               if (node_vld[lv-1][2*n+1]) begin
                  node_cnt[lv][n] = node_cnt[lv-1][2*n+1];
               end else begin
                  node_cnt[lv][n] = node_cnt[lv-1][2*n] | (node_cnt_t'(1) << (lv - 1));
               end
            end
         end
      end
   end

   assign root_vld = node_vld[L][0];
   assign root_cnt = node_cnt[L][0];

   // Only reachable when W == P and data_i == 0. Padding keeps root_vld high otherwise.
   assign lzc_d = root_vld ? CNT_W'(root_cnt) : CNT_W'(P);

   // Output register. cnt holds while valid_i is low, so X on data_i cannot reach it.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            cnt_q <= lzc_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign cnt_o   = cnt_q;

`ifdef LZC_ZERO_FLAG_EN
   logic zero_q;

   // Registered zero flag; saves a CNT_W-bit compare against W downstream.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         zero_q <= 1'b0;
      end else if (valid_i) begin
         zero_q <= ~|data_i;
      end
   end

   assign zero_o = zero_q;
`endif

endmodule

// File: tb/tb_lzc_reg.sv
// Directed and seeded-random bench for lzc_reg at W=16 and at W=11.
module tb_lzc_reg;

   logic        clk = 1'b0;
   logic        nreset;
   logic        valid16, valid11;
   logic [15:0] data16;
   logic [10:0] data11;
   logic        vout16, vout11;
   logic [4:0]  cnt16;
   logic [3:0]  cnt11;
`ifdef LZC_ZERO_FLAG_EN
   logic        zero16, zero11;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   lzc_reg #(.W(16)) dut16 (
      .clk     (clk),
      .nreset  (nreset),
      .valid_i (valid16),
      .data_i  (data16),
`ifdef LZC_ZERO_FLAG_EN
      .zero_o  (zero16),
`endif
      .valid_o (vout16),
      .cnt_o   (cnt16)
   );

   lzc_reg #(.W(11)) dut11 (
      .clk     (clk),
      .nreset  (nreset),
      .valid_i (valid11),
      .data_i  (data11),
`ifdef LZC_ZERO_FLAG_EN
      .zero_o  (zero11),
`endif
      .valid_o (vout11),
      .cnt_o   (cnt11)
   );

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Straight MSB-first bit scan.
   function automatic int unsigned ref_lzc16(input logic [15:0] d);
      for (int i = 15; i >= 0; i--) begin
         if (d[i]) return 15 - i;
      end
      return 16;
   endfunction

   // Present one valid W=16 vector and settle just after the capturing edge.
   task automatic cap16(input logic [15:0] d);
      @(negedge clk);
      valid16 = 1'b1;
      data16  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic cap11(input logic [10:0] d);
      @(negedge clk);
      valid11 = 1'b1;
      data11  = d;
      @(posedge clk);
      #1;
      valid11 = 1'b0;
   endtask

   initial begin
      logic [15:0] d;
      int unsigned exp_prev;

      nreset  = 1'b0;
      valid16 = 1'b0;
      valid11 = 1'b0;
      data16  = '0;
      data11  = '0;
      #12;
      check_eq("reset_cnt16", cnt16, 0);
      check_eq("reset_vld16", vout16, 0);
      check_eq("reset_cnt11", cnt11, 0);
      check_eq("reset_vld11", vout11, 0);
      @(negedge clk);
      nreset = 1'b1;

      // Thermometer codes
      cap16(16'hFFFF);
      check_eq("thermo_ffff", cnt16, 0);
      check_eq("thermo_ffff_vld", vout16, 1);
      for (int i = 1; i <= 15; i++) begin
         d = 16'((32'd1 << i) - 1);
         cap16(d);
         check_eq($sformatf("thermo_%04h", d), cnt16, 16 - i);
      end
      cap16(16'h0000);
      check_eq("thermo_0000", cnt16, 16);
`ifdef LZC_ZERO_FLAG_EN
      check_eq("zero_flag_set", zero16, 1);
`endif

      // Lower bits are don't-care
      cap16(16'h8000); check_eq("dc_8000", cnt16, 0);
`ifdef LZC_ZERO_FLAG_EN
      check_eq("zero_flag_clr", zero16, 0);
`endif
      cap16(16'hFFFF); check_eq("dc_ffff", cnt16, 0);
      cap16(16'h0400); check_eq("dc_0400", cnt16, 5);
      cap16(16'h07FF); check_eq("dc_07ff", cnt16, 5);
      cap16(16'h0001); check_eq("dc_0001", cnt16, 15);

      // Random, back-to-back valid; check the previous vector each cycle
      void'($urandom(10));
      exp_prev = 0;
      for (int i = 0; i <= 120; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check_eq($sformatf("rand_%0d", i - 1), cnt16, exp_prev);
            check_eq("rand_vld", vout16, 1);
         end
         d        = 16'($urandom_range(0, 65535));
         valid16  = 1'b1;
         data16   = d;
         exp_prev = ref_lzc16(d);
      end

      // Hold with valid low
      cap16(16'h00F0);
      check_eq("hold_capture", cnt16, 8);
      @(negedge clk);
      valid16 = 1'b0;
      data16  = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_eq("hold_cnt", cnt16, 8);
         check_eq("hold_vld", vout16, 0);
      end

      // Asynchronous reset between clock edges
      cap16(16'h00F0);
      valid16 = 1'b0;
      check_eq("pre_rst_cnt", cnt16, 8);
      check_eq("pre_rst_vld", vout16, 1);
      #1;
      nreset = 1'b0;
      #1;
      check_eq("async_rst_cnt", cnt16, 0);
      check_eq("async_rst_vld", vout16, 0);
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("post_rst_vld", vout16, 0);
      cap16(16'h0100);
      check_eq("post_rst_cnt", cnt16, 7);
      check_eq("post_rst_vld1", vout16, 1);

      // Non-power-of-two width
      cap11(11'h000);
      check_eq("w11_000", cnt11, 11);
      check_eq("w11_vld", vout11, 1);
`ifdef LZC_ZERO_FLAG_EN
      check_eq("w11_zero", zero11, 1);
`endif
      cap11(11'h001); check_eq("w11_001", cnt11, 10);
      cap11(11'h400); check_eq("w11_400", cnt11, 0);
      cap11(11'h0FF); check_eq("w11_0ff", cnt11, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
